// File: rtl/crc16_frame_seq_pkg.sv
// Shared types and constants for the CRC-16 frame sequencer: FSM states,
// the order in which the two CRC bytes are emitted, and the frame counter width.
package crc16_seq_pkg;

   typedef enum logic [2:0] {
      S_FILL,
      S_LOAD,
      S_STREAM,
      S_FINISH,
      S_WAIT,
      S_CAP_HI,
      S_CAP_LO,
      S_EMIT
   } seq_state_e;

   // The high CRC byte goes out first, then the low byte, which carries out_last.
   localparam int CRC_BYTES   = 2;
   localparam int CRC_HI_POS  = 0;
   localparam int CRC_LO_POS  = 1;

   localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/crc16_frame_seq_if.sv
// Byte-source, engine-pin and output-stream bundle of the frame sequencer.
// The slave modport is the sequencer's view; master is the surrounding environment.
interface crc16_frame_seq_if;
   import crc16_seq_pkg::*;

   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       in_last;

   logic       eng_load;
   logic       eng_d_finish;
   logic [7:0] eng_crc_in;
   logic [7:0] eng_crc_out;

   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_last;

   modport slave (
      input  in_valid, in_data, in_last, eng_crc_out, out_ready,
      output in_ready, eng_load, eng_d_finish, eng_crc_in, out_valid, out_data, out_last
   );

   modport master (
      output in_valid, in_data, in_last, eng_crc_out, out_ready,
      input  in_ready, eng_load, eng_d_finish, eng_crc_in, out_valid, out_data, out_last
   );

endinterface

// File: rtl/crc16_frame_seq_buf.sv
// Frame byte store: one synchronous write port, one combinational read port.
module crc16_frame_buf #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/crc16_frame_seq.sv
// Buffers one byte frame, bursts it through the external CRC engine, then
// re-emits the payload followed by the two captured CRC bytes.
module crc16_frame_seq
   import crc16_seq_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int AW      = 4,
   parameter int CRC_LAT = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   crc16_frame_seq_if.slave       bus,
   output logic                   busy,
   output logic                   drop_pulse,
   output logic [FRAME_CNT_W-1:0] frame_cnt
);

   localparam int          WW      = $clog2(CRC_LAT + 1);
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   seq_state_e             state_q, state_d;
   logic [AW:0]            wptr_q, wptr_d;
   logic [AW:0]            rptr_q, rptr_d;
   logic [AW:0]            len_q, len_d;
   logic                   ovf_q, ovf_d;
   logic [WW-1:0]          wait_q, wait_d;
   logic [7:0]             crc_hi_q, crc_hi_d;
   logic [7:0]             crc_lo_q, crc_lo_d;
   logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic                   eng_load_q, eng_load_d;
   logic                   eng_fin_q, eng_fin_d;
   logic [7:0]             eng_in_q, eng_in_d;
   logic                   out_valid_q, out_valid_d;
   logic [7:0]             out_data_q, out_data_d;
   logic                   out_last_q, out_last_d;
   logic                   drop_q, drop_d;

   logic                   accept;
   logic                   buf_we;
   logic [7:0]             rd_data;
   logic [AW:0]            crc_idx;

   crc16_frame_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
      .clk   (clk),
      .we    (buf_we),
      .waddr (wptr_q[AW-1:0]),
      .wdata (bus.in_data),
      .raddr (rptr_q[AW-1:0]),
      .rdata (rd_data)
   );

   assign accept  = (state_q == S_FILL) && bus.in_valid;
   assign crc_idx = rptr_q - len_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_FILL;
         wptr_q      <= '0;
         rptr_q      <= '0;
         len_q       <= '0;
         ovf_q       <= 1'b0;
         wait_q      <= '0;
         crc_hi_q    <= '0;
         crc_lo_q    <= '0;
         frame_cnt_q <= '0;
         eng_load_q  <= 1'b0;
         eng_fin_q   <= 1'b0;
         eng_in_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         drop_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         len_q       <= len_d;
         ovf_q       <= ovf_d;
         wait_q      <= wait_d;
         crc_hi_q    <= crc_hi_d;
         crc_lo_q    <= crc_lo_d;
         frame_cnt_q <= frame_cnt_d;
         eng_load_q  <= eng_load_d;
         eng_fin_q   <= eng_fin_d;
         eng_in_q    <= eng_in_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         drop_q      <= drop_d;
      end
   end

   // Registered outputs are computed one state ahead, so each state's
   // pin values are visible during the cycle that state is current.
   always_comb begin
      state_d     = state_q;
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      len_d       = len_q;
      ovf_d       = ovf_q;
      wait_d      = wait_q;
      crc_hi_d    = crc_hi_q;
      crc_lo_d    = crc_lo_q;
      frame_cnt_d = frame_cnt_q;
      eng_load_d  = 1'b0;
      eng_fin_d   = 1'b0;
      eng_in_d    = '0;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      drop_d      = 1'b0;
      buf_we      = 1'b0;

      case (state_q)
         S_FILL: begin
            if (accept) begin
               if (wptr_q == DEPTH_W) begin
                  ovf_d = 1'b1;
               end else begin
                  buf_we = 1'b1;
                  wptr_d = wptr_q + PTR_ONE;
               end
               if (bus.in_last) begin
                  if (ovf_q || (wptr_q == DEPTH_W)) begin
                     drop_d = 1'b1;
                     wptr_d = '0;
                     ovf_d  = 1'b0;
                  end else begin
                     len_d      = wptr_q + PTR_ONE;
                     rptr_d     = '0;
                     eng_load_d = 1'b1;
                     state_d    = S_LOAD;
                  end
               end
            end
         end
         S_LOAD: begin
            eng_in_d = rd_data;
            rptr_d   = rptr_q + PTR_ONE;
            state_d  = S_STREAM;
         end
         S_STREAM: begin
            if (rptr_q == len_q) begin
               eng_fin_d = 1'b1;
               rptr_d    = '0;
               state_d   = S_FINISH;
            end else begin
               eng_in_d = rd_data;
               rptr_d   = rptr_q + PTR_ONE;
            end
         end
         S_FINISH: begin
            wait_d  = '0;
            state_d = (CRC_LAT == 1) ? S_CAP_HI : S_WAIT;
         end
         S_WAIT: begin
            if (wait_q == WW'(CRC_LAT - 2)) begin
               state_d = S_CAP_HI;
            end else begin
               wait_d = wait_q + {{(WW-1){1'b0}}, 1'b1};
            end
         end
         S_CAP_HI: begin
            crc_hi_d = bus.eng_crc_out;
            state_d  = S_CAP_LO;
         end
         S_CAP_LO: begin
            crc_lo_d    = bus.eng_crc_out;
            out_valid_d = 1'b1;
            out_data_d  = rd_data;
            out_last_d  = 1'b0;
            rptr_d      = PTR_ONE;
            state_d     = S_EMIT;
         end
         S_EMIT: begin
            if (out_valid_q && bus.out_ready) begin
               if (out_last_q) begin
                  out_valid_d = 1'b0;
                  out_data_d  = '0;
                  out_last_d  = 1'b0;
                  frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
                  wptr_d      = '0;
                  state_d     = S_FILL;
               end else if (rptr_q < len_q) begin
                  out_data_d = rd_data;
                  rptr_d     = rptr_q + PTR_ONE;
               end else begin
                  out_data_d = (crc_idx == (AW+1)'(CRC_HI_POS)) ? crc_hi_q : crc_lo_q;
                  out_last_d = (crc_idx == (AW+1)'(CRC_LO_POS));
                  rptr_d     = rptr_q + PTR_ONE;
               end
            end
         end
         default: begin
            state_d = S_FILL;
         end
      endcase
   end

   assign bus.in_ready     = (state_q == S_FILL);
   assign bus.eng_load     = eng_load_q;
   assign bus.eng_d_finish = eng_fin_q;
   assign bus.eng_crc_in   = eng_in_q;
   assign bus.out_valid    = out_valid_q;
   assign bus.out_data     = out_data_q;
   assign bus.out_last     = out_last_q;

   assign busy       = (state_q != S_FILL);
   assign drop_pulse = drop_q;
   assign frame_cnt  = frame_cnt_q;

endmodule
